// File: rtl/bt_cmd_pkg.sv
// Shared definitions for the Bluetooth command-frame handler.
//   BT_SOF / BT_ACK / BT_NAK : frame and reply marker bytes
//   parser_state_t           : frame parser states
//   reply_state_t            : reply serialiser states
//   bt_reply_t               : {code, cmd} reply payload
package bt_cmd_pkg;

    localparam logic [7:0] BT_SOF = 8'hAA;
    localparam logic [7:0] BT_ACK = 8'h55;
    localparam logic [7:0] BT_NAK = 8'h5A;

    typedef enum logic [2:0] {
        P_SOF,
        P_CMD,
        P_LEN,
        P_PAY,
        P_CHK,
        P_DELIVER,
        P_REPLY
    } parser_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_CODE,
        R_CMD
    } reply_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] cmd;
    } bt_reply_t;

    // States in which the parser is allowed to pop bytes from the response FIFO.
    function automatic logic is_receiving(input parser_state_t s);
        return (s == P_SOF) || (s == P_CMD) || (s == P_LEN) || (s == P_PAY) || (s == P_CHK);
    endfunction

endpackage

// File: rtl/bt_reply_tx.sv
// Two-byte reply serialiser.
// Latches {code, cmd} on a start pulse, presents code then cmd on the request-FIFO
// valid/ready interface, and pulses done after the second byte transfers.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   start, reply      : launch pulse and reply payload (ignored while busy)
//   tx_fifo_data/_vld : reply byte and valid, held until accepted
//   tx_fifo_data_rdy  : request FIFO accepts byte
//   done              : one-cycle pulse after the last byte transfers
module bt_reply_tx
    import bt_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  bt_reply_t  reply,
    output logic [7:0] tx_fifo_data,
    output logic       tx_fifo_data_vld,
    input  logic       tx_fifo_data_rdy,
    output logic       done
);

    reply_state_t state_q;
    reply_state_t state_d;
    logic [7:0]   cmd_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= R_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: advance one byte per accepted transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            R_IDLE: if (start)            state_d = R_CODE;
            R_CODE: if (tx_fifo_data_rdy) state_d = R_CMD;
            R_CMD:  if (tx_fifo_data_rdy) state_d = R_IDLE;
            default:                      state_d = R_IDLE;
        endcase
    end

    // Byte/valid registers; second byte is loaded on the edge the first transfers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_fifo_data     <= 8'h00;
            tx_fifo_data_vld <= 1'b0;
            done             <= 1'b0;
            cmd_q            <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state_q)
                R_IDLE: begin
                    if (start) begin
                        tx_fifo_data     <= reply.code;
                        cmd_q            <= reply.cmd;
                        tx_fifo_data_vld <= 1'b1;
                    end
                end
                R_CODE: begin
                    if (tx_fifo_data_rdy) begin
                        tx_fifo_data <= cmd_q;
                    end
                end
                R_CMD: begin
                    if (tx_fifo_data_rdy) begin
                        tx_fifo_data     <= 8'h00;
                        tx_fifo_data_vld <= 1'b0;
                        done             <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bt_cmd_frame_handler.sv
// Command-frame handler on the FIFO side of the Bluetooth UART controller.
// Pops bytes from the response FIFO, parses SOF/CMD/LEN/payload/CHK frames,
// delivers good frames over valid/ready and queues an ACK/NAK reply into the
// request FIFO for every parsed, length-rejected or checksum-rejected frame.
// Optional feature: define BT_CMD_TIMEOUT_EN to enable the inter-byte timeout
// (TIMEOUT_CYCLES); otherwise err_timeout stays 0.
// Ports:
//   clk, rst_n                       : clock, synchronous active-low reset
//   rx_fifo_empty/_r_en/_data/_vld   : response FIFO pop interface
//   tx_fifo_data/_vld/_rdy           : request FIFO push interface (replies)
//   frame_cmd/_len/_payload/_vld/_rdy: delivered frame, valid/ready
//   err_chk, err_len, err_timeout    : one-cycle error pulses
module bt_cmd_frame_handler
    import bt_cmd_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_fifo_empty,
    output logic                     rx_fifo_r_en,
    input  logic [7:0]               rx_fifo_data,
    input  logic                     rx_fifo_data_vld,
    output logic [7:0]               tx_fifo_data,
    output logic                     tx_fifo_data_vld,
    input  logic                     tx_fifo_data_rdy,
    output logic [7:0]               frame_cmd,
    output logic [3:0]               frame_len,
    output logic [8*MAX_PAYLOAD-1:0] frame_payload,
    output logic                     frame_vld,
    input  logic                     frame_rdy,
    output logic                     err_chk,
    output logic                     err_len,
    output logic                     err_timeout
);

    localparam int unsigned PAY_W = 8 * MAX_PAYLOAD;

    if (MAX_PAYLOAD == 0 || MAX_PAYLOAD > 15 || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("bt_cmd_frame_handler: parameter out of range");
    end

    parser_state_t    state_q;
    parser_state_t    state_d;

    logic             pop_pend;
    logic [1:0]       pop_wait;
    logic             receiving_c;
    logic             byte_take_c;

    logic [7:0]       cmd_q;
    logic [3:0]       len_q;
    logic [3:0]       idx_q;
    logic [PAY_W-1:0] pay_q;
    logic [7:0]       xor_q;

    logic             err_len_c;
    logic             err_chk_c;
    logic             deliver_c;
    logic             ack_c;
    logic             timeout_hit_c;

    logic             reply_start;
    logic [7:0]       reply_code;
    logic             reply_done;
    bt_reply_t        reply;

    assign receiving_c = is_receiving(state_q);
    assign byte_take_c = pop_pend && rx_fifo_data_vld;

    // Inter-byte timeout: counts idle cycles inside a frame, cleared by every byte
`ifdef BT_CMD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic            in_frame_c;
    logic [TO_W-1:0] to_cnt_q;

    assign in_frame_c    = (state_q == P_CMD) || (state_q == P_LEN) ||
                           (state_q == P_PAY) || (state_q == P_CHK);
    assign timeout_hit_c = in_frame_c && !byte_take_c &&
                           (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || !in_frame_c || byte_take_c || timeout_hit_c) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end
`else
    assign timeout_hit_c = 1'b0;
`endif

    // Parser state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= P_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    // Parser next state and per-cycle event flags
    always_comb begin
        state_d   = state_q;
        err_len_c = 1'b0;
        err_chk_c = 1'b0;
        deliver_c = 1'b0;
        ack_c     = 1'b0;
        case (state_q)
            P_SOF: begin
                if (byte_take_c && rx_fifo_data == BT_SOF) state_d = P_CMD;
            end
            P_CMD: begin
                if (byte_take_c) state_d = P_LEN;
            end
            P_LEN: begin
                if (byte_take_c) begin
                    if (rx_fifo_data > 8'(MAX_PAYLOAD)) begin
                        err_len_c = 1'b1;
                        state_d   = P_REPLY;
                    end else if (rx_fifo_data == 8'h00) begin
                        state_d = P_CHK;
                    end else begin
                        state_d = P_PAY;
                    end
                end
            end
            P_PAY: begin
                if (byte_take_c && idx_q == len_q - 4'd1) state_d = P_CHK;
            end
            P_CHK: begin
                if (byte_take_c) begin
                    if (rx_fifo_data == xor_q) begin
                        deliver_c = 1'b1;
                        state_d   = P_DELIVER;
                    end else begin
                        err_chk_c = 1'b1;
                        state_d   = P_REPLY;
                    end
                end
            end
            P_DELIVER: begin
                if (frame_vld && frame_rdy) begin
                    ack_c   = 1'b1;
                    state_d = P_REPLY;
                end
            end
            P_REPLY: begin
                if (reply_done) state_d = P_SOF;
            end
            default: state_d = P_SOF;
        endcase
        // Timeout only fires in a cycle without a byte, so it never races a flag above
        if (timeout_hit_c) state_d = P_SOF;
    end

    // Pop engine: one pulse, then up to 2 cycles for the byte before re-arming
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_fifo_r_en <= 1'b0;
            pop_pend     <= 1'b0;
            pop_wait     <= 2'd0;
        end else begin
            rx_fifo_r_en <= 1'b0;
            if (pop_pend) begin
                if (byte_take_c || timeout_hit_c || !receiving_c) begin
                    pop_pend <= 1'b0;
                end else if (pop_wait == 2'd2) begin
                    pop_pend <= 1'b0;
                end else begin
                    pop_wait <= pop_wait + 2'd1;
                end
            end else if (receiving_c && !rx_fifo_empty) begin
                rx_fifo_r_en <= 1'b1;
                pop_pend     <= 1'b1;
                pop_wait     <= 2'd0;
            end
        end
    end

    // Frame assembly, output frame registers, error pulses and reply launch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q         <= 8'h00;
            len_q         <= 4'd0;
            idx_q         <= 4'd0;
            pay_q         <= '0;
            xor_q         <= 8'h00;
            frame_cmd     <= 8'h00;
            frame_len     <= 4'd0;
            frame_payload <= '0;
            frame_vld     <= 1'b0;
            err_chk       <= 1'b0;
            err_len       <= 1'b0;
            err_timeout   <= 1'b0;
            reply_start   <= 1'b0;
            reply_code    <= 8'h00;
        end else begin
            err_chk     <= err_chk_c;
            err_len     <= err_len_c;
            err_timeout <= timeout_hit_c;
            // Launch the serialiser on the first cycle spent in P_REPLY
            reply_start <= (state_d == P_REPLY) && (state_q != P_REPLY);

            if (err_len_c || err_chk_c) begin
                reply_code <= BT_NAK;
            end else if (ack_c) begin
                reply_code <= BT_ACK;
            end

            case (state_q)
                P_SOF: begin
                    xor_q <= 8'h00;
                    pay_q <= '0;
                end
                P_CMD: begin
                    if (byte_take_c) begin
                        cmd_q <= rx_fifo_data;
                        xor_q <= xor_q ^ rx_fifo_data;
                    end
                end
                P_LEN: begin
                    if (byte_take_c) begin
                        len_q <= 4'(rx_fifo_data);
                        idx_q <= 4'd0;
                        xor_q <= xor_q ^ rx_fifo_data;
                    end
                end
                P_PAY: begin
                    if (byte_take_c) begin
                        pay_q[{idx_q, 3'b000} +: 8] <= rx_fifo_data;
                        idx_q                       <= idx_q + 4'd1;
                        xor_q                       <= xor_q ^ rx_fifo_data;
                    end
                end
                default: ;
            endcase

            if (deliver_c) begin
                frame_cmd     <= cmd_q;
                frame_len     <= len_q;
                frame_payload <= pay_q;
                frame_vld     <= 1'b1;
            end else if (ack_c) begin
                frame_vld <= 1'b0;
            end
        end
    end

    // A length-error NAK reuses cmd_q, which already holds the received CMD
    assign reply = '{code: reply_code, cmd: cmd_q};

    bt_reply_tx u_reply_tx (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (reply_start),
        .reply            (reply),
        .tx_fifo_data     (tx_fifo_data),
        .tx_fifo_data_vld (tx_fifo_data_vld),
        .tx_fifo_data_rdy (tx_fifo_data_rdy),
        .done             (reply_done)
    );

endmodule

// File: tb/tb_bt_cmd_frame_handler.sv
// Directed self-checking bench for bt_cmd_frame_handler (MAX_PAYLOAD=4).
// A small response-FIFO model returns a popped byte the cycle after rx_fifo_r_en;
// a monitor collects every accepted reply byte for comparison.
module tb_bt_cmd_frame_handler;

    localparam int unsigned MAXP = 4;
    localparam int unsigned PW   = 8 * MAXP;

    logic          clk;
    logic          rst_n;
    logic          rx_fifo_empty;
    logic          rx_fifo_r_en;
    logic [7:0]    rx_fifo_data;
    logic          rx_fifo_data_vld;
    logic [7:0]    tx_fifo_data;
    logic          tx_fifo_data_vld;
    logic          tx_fifo_data_rdy;
    logic [7:0]    frame_cmd;
    logic [3:0]    frame_len;
    logic [PW-1:0] frame_payload;
    logic          frame_vld;
    logic          frame_rdy;
    logic          err_chk;
    logic          err_len;
    logic          err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] txq [$];

    int  n_err_chk = 0;
    int  n_err_len = 0;
    int  n_err_to  = 0;
    int  n_r_en    = 0;
    int  n_frames  = 0;
    logic frame_vld_d = 1'b0;

    bt_cmd_frame_handler #(
        .MAX_PAYLOAD    (MAXP),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rx_fifo_empty    (rx_fifo_empty),
        .rx_fifo_r_en     (rx_fifo_r_en),
        .rx_fifo_data     (rx_fifo_data),
        .rx_fifo_data_vld (rx_fifo_data_vld),
        .tx_fifo_data     (tx_fifo_data),
        .tx_fifo_data_vld (tx_fifo_data_vld),
        .tx_fifo_data_rdy (tx_fifo_data_rdy),
        .frame_cmd        (frame_cmd),
        .frame_len        (frame_len),
        .frame_payload    (frame_payload),
        .frame_vld        (frame_vld),
        .frame_rdy        (frame_rdy),
        .err_chk          (err_chk),
        .err_len          (err_len),
        .err_timeout      (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rx_fifo_empty = (rd_ptr == wr_ptr);

    // Response FIFO model: byte appears the cycle after the pop pulse
    always @(posedge clk) begin
        rx_fifo_data_vld <= 1'b0;
        if (rx_fifo_r_en && rd_ptr != wr_ptr) begin
            rx_fifo_data     <= mem[rd_ptr[7:0]];
            rx_fifo_data_vld <= 1'b1;
            rd_ptr           <= rd_ptr + 1;
        end
    end

    // Monitor: accepted reply bytes and event counters
    always @(posedge clk) begin
        if (rst_n) begin
            if (tx_fifo_data_vld && tx_fifo_data_rdy) txq.push_back(tx_fifo_data);
            if (err_chk)     n_err_chk++;
            if (err_len)     n_err_len++;
            if (err_timeout) n_err_to++;
            if (rx_fifo_r_en) n_r_en++;
            if (frame_vld && !frame_vld_d) n_frames++;
        end
        frame_vld_d = frame_vld;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    // Wait for a delivered frame, check it, then complete the handshake
    task automatic take_frame(input string tag, input logic [7:0] cmd,
                              input logic [3:0] len, input logic [PW-1:0] pay);
        int n = 0;
        while (!frame_vld && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_vld"}, 64'(frame_vld), 64'(1));
        check({tag, "_cmd"}, 64'(frame_cmd), 64'(cmd));
        check({tag, "_len"}, 64'(frame_len), 64'(len));
        check({tag, "_pay"}, 64'(frame_payload), 64'(pay));
        frame_rdy = 1'b1;
        @(negedge clk);
        frame_rdy = 1'b0;
        check({tag, "_vld_drop"}, 64'(frame_vld), 64'(0));
    endtask

    // Wait for two reply bytes and compare them
    task automatic expect_reply(input string tag, input logic [7:0] code, input logic [7:0] cmd);
        int n = 0;
        while (txq.size() < 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_nbytes"}, 64'(txq.size()), 64'(2));
        if (txq.size() >= 2) begin
            check({tag, "_code"}, 64'(txq.pop_front()), 64'(code));
            check({tag, "_cmd"},  64'(txq.pop_front()), 64'(cmd));
        end
        repeat (3) @(negedge clk);
        check({tag, "_extra"}, 64'(txq.size()), 64'(0));
        txq.delete();
    endtask

    initial begin
        int base;
        int n;
        rst_n            = 1'b0;
        frame_rdy        = 1'b0;
        tx_fifo_data_rdy = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_r_en",     64'(rx_fifo_r_en),     64'(0));
        check("rst_tx_vld",   64'(tx_fifo_data_vld), 64'(0));
        check("rst_tx_data",  64'(tx_fifo_data),     64'(0));
        check("rst_frame_vld",64'(frame_vld),        64'(0));
        check("rst_cmd",      64'(frame_cmd),        64'(0));
        check("rst_len",      64'(frame_len),        64'(0));
        check("rst_pay",      64'(frame_payload),    64'(0));
        check("rst_err",      64'({err_chk, err_len, err_timeout}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // CHK = 01^02^10^20 = 33
        push(8'hAA); push(8'h01); push(8'h02); push(8'h10); push(8'h20); push(8'h33);
        n = 0;
        while (!frame_vld && n < 300) begin @(negedge clk); n++; end
        repeat (3) begin
            @(negedge clk);
            check("f1_hold_vld",  64'(frame_vld),        64'(1));
            check("f1_hold_pay",  64'(frame_payload),    64'(32'h0000_2010));
            check("f1_no_reply",  64'(tx_fifo_data_vld), 64'(0));
        end
        take_frame("f1", 8'h01, 4'd2, 32'h0000_2010);
        expect_reply("f1_rep", 8'h55, 8'h01);

        // Zero-length frame
        push(8'hAA); push(8'h07); push(8'h00); push(8'h07);
        take_frame("f0len", 8'h07, 4'd0, 32'h0);
        expect_reply("f0len_rep", 8'h55, 8'h07);

        // Full payload; CHK = 09^04^11^22^33^44 = 49
        push(8'hAA); push(8'h09); push(8'h04);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h49);
        take_frame("fmax", 8'h09, 4'd4, 32'h4433_2211);
        expect_reply("fmax_rep", 8'h55, 8'h09);

        // 0xAA inside a frame is payload; CHK = 0A^01^AA = A1
        push(8'hAA); push(8'h0A); push(8'h01); push(8'hAA); push(8'hA1);
        take_frame("faa", 8'h0A, 4'd1, 32'h0000_00AA);
        expect_reply("faa_rep", 8'h55, 8'h0A);

        // Checksum error: 03^01^FF = FD, received 00
        base = n_frames;
        push(8'hAA); push(8'h03); push(8'h01); push(8'hFF); push(8'h00);
        n = 0;
        while (!err_chk && n < 300) begin @(negedge clk); n++; end
        check("chk_pulse",      64'(err_chk),          64'(1));
        check("chk_tx_not_yet", 64'(tx_fifo_data_vld), 64'(0));
        @(negedge clk);
        check("chk_pulse_end",  64'(err_chk),          64'(0));
        check("chk_tx_vld",     64'(tx_fifo_data_vld), 64'(1));
        check("chk_tx_data",    64'(tx_fifo_data),     64'(8'h5A));
        expect_reply("chk_rep", 8'h5A, 8'h03);
        check("chk_no_frame",   64'(n_frames - base),  64'(0));
        check("chk_count",      64'(n_err_chk),        64'(1));

        // Length error then a normal frame queued right behind it
        push(8'hAA); push(8'h04); push(8'h09);
        push(8'hAA); push(8'h01); push(8'h00); push(8'h01);
        expect_reply("len_rep", 8'h5A, 8'h04);
        check("len_count", 64'(n_err_len), 64'(1));
        take_frame("after_len", 8'h01, 4'd0, 32'h0);
        expect_reply("after_len_rep", 8'h55, 8'h01);

        // Reply backpressure with more bytes waiting in the response FIFO
        tx_fifo_data_rdy = 1'b0;
        push(8'hAA); push(8'h05); push(8'h00); push(8'h05);
        push(8'hAA); push(8'h06); push(8'h00); push(8'h06);
        take_frame("stall", 8'h05, 4'd0, 32'h0);
        n = 0;
        while (!tx_fifo_data_vld && n < 50) begin @(negedge clk); n++; end
        base = n_r_en;
        repeat (20) begin
            @(negedge clk);
            check("stall_vld",  64'(tx_fifo_data_vld), 64'(1));
            check("stall_data", 64'(tx_fifo_data),     64'(8'h55));
        end
        check("stall_no_pop", 64'(n_r_en - base), 64'(0));
        tx_fifo_data_rdy = 1'b1;
        expect_reply("stall_rep", 8'h55, 8'h05);
        take_frame("post_stall", 8'h06, 4'd0, 32'h0);
        expect_reply("post_stall_rep", 8'h55, 8'h06);

`ifdef BT_CMD_TIMEOUT_EN
        // Partial frame abandoned after 100 idle cycles, no reply
        push(8'hAA); push(8'h01);
        n = 0;
        while (n_err_to == 0 && n < 400) begin @(negedge clk); n++; end
        check("to_pulse", 64'(n_err_to), 64'(1));
        repeat (10) @(negedge clk);
        check("to_no_reply", 64'(txq.size()), 64'(0));
        push(8'hAA); push(8'h02); push(8'h00); push(8'h02);
        take_frame("after_to", 8'h02, 4'd0, 32'h0);
        expect_reply("after_to_rep", 8'h55, 8'h02);
`else
        check("to_never", 64'(n_err_to), 64'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
